// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: active-low glyphs,
// blank pattern and anode idle level.
package ssd_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic       AN_IDLE = 1'b1;

    // abcdefg, a = bit 6, active-low
    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: return GLYPH_0;
            4'h1: return GLYPH_1;
            4'h2: return GLYPH_2;
            4'h3: return GLYPH_3;
            4'h4: return GLYPH_4;
            4'h5: return GLYPH_5;
            4'h6: return GLYPH_6;
            4'h7: return GLYPH_7;
            4'h8: return GLYPH_8;
            4'h9: return GLYPH_9;
            4'hA: return GLYPH_A;
            4'hB: return GLYPH_B;
            4'hC: return GLYPH_C;
            4'hD: return GLYPH_D;
            4'hE: return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_hex7_decode.sv
// Combinational nibble to active-low abcdefg decoder; blank when not enabled.
module hex7_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       en,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (en) seg = hex_glyph(nibble);
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed N-digit common-anode display scanner with frame snapshots,
// per-digit enable, decimal points, leading-zero blanking and PWM dimming.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int TICK_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [TICK_LOG2-1:0]  tick;
    logic [IDX_W-1:0]      idx;
    logic                  first;
    logic [4*N_DIGITS-1:0] snap_val;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_en;
    logic                  snap_lz;

    logic tick_wrap;
    logic frame_wrap;
    assign tick_wrap  = &tick;
    assign frame_wrap = tick_wrap && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick     <= '0;
            idx      <= '0;
            first    <= 1'b1;
            snap_val <= '0;
            snap_dp  <= '0;
            snap_en  <= '0;
            snap_lz  <= 1'b0;
        end else begin
            tick  <= tick + 1'b1;
            first <= 1'b0;
            if (tick_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (first || frame_wrap) begin
                snap_val <= value;
                snap_dp  <= dp;
                snap_en  <= digit_en;
                snap_lz  <= lz_blank;
            end
        end
    end

    // The first cycle after reset displays digit 0 from the snapshot being
    // loaded in that same cycle, so bypass the not-yet-loaded registers.
    logic [4*N_DIGITS-1:0] cur_val;
    logic [N_DIGITS-1:0]   cur_dp;
    logic [N_DIGITS-1:0]   cur_en;
    logic                  cur_lz;
    assign cur_val = first ? value    : snap_val;
    assign cur_dp  = first ? dp       : snap_dp;
    assign cur_en  = first ? digit_en : snap_en;
    assign cur_lz  = first ? lz_blank : snap_lz;

    logic [N_DIGITS-1:0] lz_mask;
    logic                upper_zero;
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (cur_val[4*i +: 4] == 4'h0);
            lz_mask[i] = cur_lz && upper_zero;
        end
    end

    logic [3:0] nib_sel;
    logic       en_sel;
    logic       dp_sel;
    logic       blank_sel;
    always_comb begin
        nib_sel   = 4'h0;
        en_sel    = 1'b0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_sel   = cur_val[4*i +: 4];
                en_sel    = cur_en[i];
                dp_sel    = cur_dp[i];
                blank_sel = lz_mask[i];
            end
        end
    end

    logic pwm_on;
    logic show;
    assign pwm_on = (brightness == 4'hF) || (tick[TICK_LOG2-1 -: 4] < brightness);
    assign show   = pwm_on && en_sel && !blank_sel;

    logic [6:0] seg_dec;
    hex7_decode u_dec (
        .nibble (nib_sel),
        .en     (show),
        .seg    (seg_dec)
    );

    logic [N_DIGITS-1:0] an_next;
    always_comb begin
        an_next = {N_DIGITS{AN_IDLE}};
        for (int i = 0; i < N_DIGITS; i++) begin
            if (show && (idx == IDX_W'(i))) an_next[i] = ~AN_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg         <= SEG_OFF;
            dp_n        <= 1'b1;
            an          <= {N_DIGITS{AN_IDLE}};
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_dec;
            dp_n        <= ~(show && dp_sel);
            an          <= an_next;
            frame_start <= (tick == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: a 4-digit and a 3-digit build, 16-clock slots.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  brightness = 4'hF;

    logic [6:0]  seg, seg3;
    logic        dp_n, dp_n3;
    logic [3:0]  an;
    logic [2:0]  an3;
    logic        frame_start, frame_start3;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] G0  = 7'b0000001;
    localparam logic [6:0] G1  = 7'b1001111;
    localparam logic [6:0] G2  = 7'b0010010;
    localparam logic [6:0] G5  = 7'b0100100;
    localparam logic [6:0] GA  = 7'b0001000;
    localparam logic [6:0] GF  = 7'b0111000;

    // Glyphs for value 16'h12AF, digit 0 first
    logic [6:0] tab_12af [4];

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.N_DIGITS(4), .TICK_LOG2(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .dp          (dp),
        .digit_en    (digit_en),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .seg         (seg),
        .dp_n        (dp_n),
        .an          (an),
        .frame_start (frame_start)
    );

    ssd_scan_ctrl #(.N_DIGITS(3), .TICK_LOG2(4)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .value       (value[11:0]),
        .dp          (dp[2:0]),
        .digit_en    (digit_en[2:0]),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .seg         (seg3),
        .dp_n        (dp_n3),
        .an          (an3),
        .frame_start (frame_start3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the first registered output cycle after reset.
    task automatic reset_release();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (an !== 4'hF) begin tests_failed++; $display("FAIL reset_an got %b want 1111", an); end
        tests_run++;
        if (seg !== OFF) begin tests_failed++; $display("FAIL reset_seg got %b want %b", seg, OFF); end
        tests_run++;
        if (dp_n !== 1'b1) begin tests_failed++; $display("FAIL reset_dp_n got %b want 1", dp_n); end
        tests_run++;
        if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs got %b want 0", frame_start); end
        tests_run++;
        if (an3 !== 3'h7) begin tests_failed++; $display("FAIL reset_an3 got %b want 111", an3); end
    endtask

    task automatic test_scan();
        value = 16'h12AF; digit_en = 4'hF; dp = 4'h0; lz_blank = 1'b0; brightness = 4'hF;
        reset_release();
        for (int n = 0; n < 64; n++) begin
            int d;
            logic [3:0] ea;
            d  = n / 16;
            ea = ~(4'b0001 << d);
            tests_run++;
            if (an !== ea) begin tests_failed++; $display("FAIL scan_an n=%0d got %b want %b", n, an, ea); end
            tests_run++;
            if (seg !== tab_12af[d]) begin tests_failed++; $display("FAIL scan_seg n=%0d got %b want %b", n, seg, tab_12af[d]); end
            tests_run++;
            if (frame_start !== (n == 0)) begin tests_failed++; $display("FAIL scan_fs n=%0d got %b want %b", n, frame_start, (n == 0)); end
            tests_run++;
            if (dp_n !== 1'b1) begin tests_failed++; $display("FAIL scan_dp_n n=%0d got %b want 1", n, dp_n); end
            step();
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2];
        logic [6:0]  g0s  [2];
        vals[0] = 16'h0005; g0s[0] = G5;
        vals[1] = 16'h0000; g0s[1] = G0;
        for (int t = 0; t < 2; t++) begin
            value = vals[t]; digit_en = 4'hF; dp = 4'h0; lz_blank = 1'b1; brightness = 4'hF;
            reset_release();
            for (int n = 0; n < 64; n++) begin
                int d;
                logic [3:0] ea;
                logic [6:0] es;
                d  = n / 16;
                ea = (d == 0) ? 4'b1110 : 4'b1111;
                es = (d == 0) ? g0s[t] : OFF;
                tests_run++;
                if (an !== ea) begin tests_failed++; $display("FAIL lz_an t=%0d n=%0d got %b want %b", t, n, an, ea); end
                tests_run++;
                if (seg !== es) begin tests_failed++; $display("FAIL lz_seg t=%0d n=%0d got %b want %b", t, n, seg, es); end
                step();
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_coherent();
        value = 16'h1111; digit_en = 4'hF; dp = 4'h0; lz_blank = 1'b0; brightness = 4'hF;
        reset_release();
        for (int n = 0; n < 128; n++) begin
            int d;
            logic [3:0] ea;
            logic [6:0] es;
            d  = (n / 16) % 4;
            ea = ~(4'b0001 << d);
            es = (n < 64) ? G1 : G2;
            tests_run++;
            if (an !== ea) begin tests_failed++; $display("FAIL coh_an n=%0d got %b want %b", n, an, ea); end
            tests_run++;
            if (seg !== es) begin tests_failed++; $display("FAIL coh_seg n=%0d got %b want %b", n, seg, es); end
            tests_run++;
            if (frame_start !== (n == 0 || n == 64)) begin tests_failed++; $display("FAIL coh_fs n=%0d got %b want %b", n, frame_start, (n == 0 || n == 64)); end
            if (n == 40) value = 16'h2222;
            step();
        end
    endtask

    task automatic test_pwm();
        value = 16'h12AF; digit_en = 4'hF; dp = 4'h0; lz_blank = 1'b0; brightness = 4'd4;
        reset_release();
        for (int n = 0; n < 64; n++) begin
            int d, k;
            logic [3:0] ea;
            d  = n / 16;
            k  = n % 16;
            ea = (k < 4) ? ~(4'b0001 << d) : 4'b1111;
            tests_run++;
            if (an !== ea) begin tests_failed++; $display("FAIL pwm4_an n=%0d got %b want %b", n, an, ea); end
            step();
        end
        brightness = 4'd0;
        step();
        for (int n = 0; n < 64; n++) begin
            tests_run++;
            if (an !== 4'hF) begin tests_failed++; $display("FAIL pwm0_an n=%0d got %b want 1111", n, an); end
            step();
        end
        brightness = 4'hF;
    endtask

    task automatic test_enable_dp();
        logic [3:0] dps  [2];
        logic [3:0] dpne [2];
        dps[0] = 4'b0001; dpne[0] = 4'b1111;
        dps[1] = 4'b0010; dpne[1] = 4'b1101;
        for (int t = 0; t < 2; t++) begin
            value = 16'h12AF; digit_en = 4'b1010; dp = dps[t]; lz_blank = 1'b0; brightness = 4'hF;
            reset_release();
            for (int n = 0; n < 64; n++) begin
                int d;
                logic lit;
                logic [3:0] ea;
                logic [6:0] es;
                d   = n / 16;
                lit = (d == 1) || (d == 3);
                ea  = lit ? ~(4'b0001 << d) : 4'b1111;
                es  = lit ? tab_12af[d] : OFF;
                tests_run++;
                if (an !== ea) begin tests_failed++; $display("FAIL en_an t=%0d n=%0d got %b want %b", t, n, an, ea); end
                tests_run++;
                if (seg !== es) begin tests_failed++; $display("FAIL en_seg t=%0d n=%0d got %b want %b", t, n, seg, es); end
                tests_run++;
                if (dp_n !== dpne[t][d]) begin tests_failed++; $display("FAIL en_dp_n t=%0d n=%0d got %b want %b", t, n, dp_n, dpne[t][d]); end
                step();
            end
        end
        digit_en = 4'hF; dp = 4'h0;
    endtask

    task automatic test_n3_and_midreset();
        value = 16'h12AF; digit_en = 4'hF; dp = 4'h0; lz_blank = 1'b0; brightness = 4'hF;
        reset_release();
        for (int n = 0; n < 144; n++) begin
            int d;
            logic [2:0] ea;
            d  = (n / 16) % 3;
            ea = ~(3'b001 << d);
            tests_run++;
            if (an3 !== ea) begin tests_failed++; $display("FAIL n3_an n=%0d got %b want %b", n, an3, ea); end
            tests_run++;
            if (seg3 !== tab_12af[d]) begin tests_failed++; $display("FAIL n3_seg n=%0d got %b want %b", n, seg3, tab_12af[d]); end
            tests_run++;
            if (frame_start3 !== (n % 48 == 0)) begin tests_failed++; $display("FAIL n3_fs n=%0d got %b want %b", n, frame_start3, (n % 48 == 0)); end
            step();
        end
        repeat (20) step();
        tests_run++;
        if (an3 !== 3'b101) begin tests_failed++; $display("FAIL n3_premid_an got %b want 101", an3); end
        rst = 1'b1;
        step();
        tests_run++;
        if (an3 !== 3'b111) begin tests_failed++; $display("FAIL mid_rst_an3 got %b want 111", an3); end
        tests_run++;
        if (an !== 4'b1111) begin tests_failed++; $display("FAIL mid_rst_an got %b want 1111", an); end
        tests_run++;
        if (seg3 !== OFF) begin tests_failed++; $display("FAIL mid_rst_seg3 got %b want %b", seg3, OFF); end
        step();
        rst = 1'b0;
        step();
        tests_run++;
        if (an3 !== 3'b110) begin tests_failed++; $display("FAIL restart_an3 got %b want 110", an3); end
        tests_run++;
        if (frame_start3 !== 1'b1) begin tests_failed++; $display("FAIL restart_fs3 got %b want 1", frame_start3); end
        tests_run++;
        if (seg3 !== GF) begin tests_failed++; $display("FAIL restart_seg3 got %b want %b", seg3, GF); end
        tests_run++;
        if (an !== 4'b1110) begin tests_failed++; $display("FAIL restart_an got %b want 1110", an); end
    endtask

    initial begin
        tab_12af[0] = GF;
        tab_12af[1] = GA;
        tab_12af[2] = G2;
        tab_12af[3] = G1;
        test_reset();
        test_scan();
        test_lz();
        test_coherent();
        test_pwm();
        test_enable_dp();
        test_n3_and_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Parametrised multiplexed seven-segment display controller. Drives an N-digit common-anode display from a packed hex value with an internal hex-to-segment decoder. Adds features the fixed 4-digit router lacks: frame-coherent snapshotting, per-digit enable, decimal points, leading-zero blanking and PWM brightness. Sits between the datapath result registers and the board display pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned, 1..16.
- `TICK_LOG2`, 16: digit slot length is 2^TICK_LOG2 clocks, ≥4. 16 gives 655.36 µs at 100 MHz.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `value` in 4*N_DIGITS: hex nibbles; digit i = `value[4i+3:4i]`, digit 0 rightmost.
- `dp` in N_DIGITS: decimal point request per digit, 1 = lit.
- `digit_en` in N_DIGITS: 0 forces the digit blank; its anode stays off.
- `lz_blank` in 1: 1 = suppress leading zeros.
- `brightness` in 4: on-time within each slot, in sixteenths. 15 = 100 %, 0 = off.
- `seg` out 7: abcdefg, active-low. a = bit 6, g = bit 0.
- `dp_n` out 1: decimal point segment, active-low.
- `an` out N_DIGITS: anodes, active-low, one-hot-low or all high.
- `frame_start` out 1: one-cycle pulse when digit 0's slot begins with a fresh snapshot.

## Operation
- Slot counter `tick`, TICK_LOG2 bits, increments every clock and wraps to 0.
- Digit index `idx`, 0..N_DIGITS-1. It advances when `tick` wraps. After N_DIGITS-1 it wraps to 0, and the wrap covers non-power-of-two N_DIGITS.
- Snapshot registers `snap_val`, `snap_dp`, `snap_en`, `snap_lz` load `value`, `dp`, `digit_en`, `lz_blank`:
  - on the first cycle after `rst` deasserts;
  - on every cycle where `tick` wraps and `idx` = N_DIGITS-1.
  - `brightness` is not snapshotted; it is sampled live.
- Leading-zero blanking is computed from the snapshot.
  - Digit i is blanked when `snap_lz`=1, i>0, and digits i..N_DIGITS-1 are all 0.
  - Digit 0 is never blanked by the leading-zero rule.
  - Disabled digits count as their nibble value for this rule.
- Decoder maps 0-F to standard hex glyphs, active-low. Examples: 0→0000001, 1→1001111, A→0001000, b→1100000, F→0111000.
- PWM window: `on` is 1 when `brightness`=15, or when `tick[TICK_LOG2-1:TICK_LOG2-4]` < `brightness`.
- Active digit is displayed when `on`, `snap_en[idx]`=1 and the digit is not leading-zero-blanked. In that case:
  - `an[idx]`=0 and all other anodes are 1;
  - `seg` = decode of the snapshot nibble;
  - `dp_n` = ~`snap_dp[idx]`.
- Otherwise `an` is all 1s, `seg`=1111111 and `dp_n`=1.
- A blanked or dark digit still occupies its full slot; the scan rate does not change.

## Timing
- Reset values: `tick`=0, `idx`=0, snapshots 0, `seg`=1111111, `dp_n`=1, `an`=all 1s, `frame_start`=0. All are held while `rst`=1.
- `rst` asserted mid-frame: outputs go dark on the next edge and the scan restarts at digit 0. No glitch anode is permitted.
- All outputs are registered: they reflect the `tick`/`idx`/snapshot state of the previous cycle, a fixed 1-cycle latency.
- `frame_start` is registered. It is high in the first output cycle of digit 0, both after reset and after each frame wrap.
- `value` changes take effect only at the next frame boundary. A mid-frame change never appears on any digit of the current frame.
- A `brightness` change takes effect within one clock, with 1-cycle latency.
- Frame period is N_DIGITS × 2^TICK_LOG2 clocks.

## Structure
- Shared package `ssd_pkg`:
  - active-low glyph constants for 0-F;
  - `SEG_OFF` = 7'b1111111;
  - anode-idle constant.
- Sub-module `hex7_decode`: combinational nibble→abcdefg with an enable; when disabled it outputs `SEG_OFF`. Instantiated once, on the muxed snapshot nibble.
- Top holds the counters, snapshots, leading-zero logic, PWM compare and output registers.

## Test plan
Bench parameters: TICK_LOG2=4, N_DIGITS=4.
1. Reset release with `value`=16'h12AF, all enabled, `brightness`=15, `lz_blank`=0:
   - `frame_start` pulses;
   - `an` steps 1110, 1101, 1011, 0111, 16 clocks each;
   - `seg` steps 0111000, 0001000, 0010010, 1001111.
2. `value`=16'h0005, `lz_blank`=1: digits 3..1 have `an`=1111; digit 0 shows 0100100. Repeat with `value`=16'h0000: only digit 0 is lit, showing 0000001.
3. Change `value` from 16'h1111 to 16'h2222 during digit 2's slot: digits 2 and 3 still show 1 in that frame; every digit shows 2 after the next `frame_start`.
4. `brightness`=4: the anode is low for `tick` 0..3 and high for 4..15 in each slot. `brightness`=0: `an` stays 1111 permanently.
5. `digit_en`=4'b1010, `dp`=4'b0001: digits 0 and 2 stay dark including their decimal point; digits 1 and 3 are lit with `dp_n`=1. With `dp`=4'b0010, digit 1 has `dp_n`=0.
6. N_DIGITS=3 build: `idx` wraps 2→0 and `frame_start` arrives every 48 clocks. Assert `rst` mid-slot: `an`=111 on the next edge, then digit 0 restarts.
